// File: rtl/handshake_const_check.sv
// handshake_const_check
//   Sink for a constant-producing valid/ready data channel. Every accepted token
//   is compared against EXPECTED; saturating match/mismatch counters and a sticky
//   error (with the first offending value) record the outcome. One dataless
//   control token is returned upstream per accepted input, buffered by a
//   two-entry credit counter so the block keeps full throughput.
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   ins, ins_valid   input data token and its valid
//   ins_ready        block can accept a token (pending < 2)
//   ctrl_valid       control token available (pending != 0)
//   ctrl_ready       downstream takes the control token
//   match_count      accepted tokens equal to EXPECTED (saturating)
//   mismatch_count   accepted tokens differing from EXPECTED (saturating)
//   error            sticky: a mismatch has been seen since reset
//   first_bad        value of the first mismatching token, 0 until error
module handshake_const_check #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] EXPECTED   = 32'hB902,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  ctrl_valid,
  input  logic                  ctrl_ready,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] first_bad
);

  // Reference value resized to the data width (zero-extended or truncated).
  localparam logic [DATA_WIDTH-1:0] EXP_VAL = DATA_WIDTH'(EXPECTED);

  typedef enum logic {
    ST_OK   = 1'b0,
    ST_FAIL = 1'b1
  } state_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [1:0] pending;
  state_t     state;
  logic       acc;
  logic       emt;
  logic       eq;

  // Handshakes use only registered flags, so there is no combinational path
  // from ctrl_ready to ins_ready or from ins_valid to ctrl_valid.
  assign ins_ready  = (pending != 2'd2);
  assign ctrl_valid = (pending != 2'd0);
  assign acc        = ins_valid & ins_ready;
  assign emt        = ctrl_valid & ctrl_ready;
  assign eq         = (ins == EXP_VAL);
  assign error      = (state == ST_FAIL);

  // Control credit: one pending control token per accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 2'd0;
    end else begin
      pending <= pending + {1'b0, acc} - {1'b0, emt};
    end
  end

  // Statistics: only touched on acceptance, so ins is ignored while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count    <= '0;
      mismatch_count <= '0;
    end else if (acc) begin
      if (eq) match_count    <= sat_inc(match_count);
      else    mismatch_count <= sat_inc(mismatch_count);
    end
  end

  // Sticky failure FSM; first_bad is captured only on the OK -> FAIL edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_OK;
      first_bad <= '0;
    end else begin
      case (state)
        ST_OK: begin
          if (acc && !eq) begin
            state     <= ST_FAIL;
            first_bad <= ins;
          end
        end
        ST_FAIL: state <= ST_FAIL;
        default: state <= ST_OK;
      endcase
    end
  end

endmodule
